tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the 16-tap delay-line TDC. It does four things:
- arms the delay line on a start request and counts coarse clock cycles until the stop hit;
- captures the 16-bit thermometer word and drives the external 16-to-4 priority encoder (enable plus word);
- merges the 4-bit fine code with the coarse count into one timestamp;
- presents the timestamp on a valid/ready output handshake.

It sits between the delay-line capture flops and the readout logic.

Parameters:
CW, 8, coarse counter width (bits); timestamp width is CW+4
TIMEOUT, 255, coarse count at which a pending measurement is aborted; must be < 2^CW

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse requesting a measurement; ignored unless state is IDLE
stop_hit  in  1  synchronised stop-event flag from the delay-line front end
therm  in  16  thermometer word sampled from the delay line
dl_arm  out  1  delay-line arm, high in ARMED only
enc_en  out  1  encoder enable, high in ENCODE only
enc_ip  out  16  registered thermometer word driven to the encoder
enc_op  in  4  encoder result (combinational from enc_ip/enc_en)
ts  out  CW+4  timestamp {coarse, fine}
ts_valid  out  1  timestamp valid
ts_ready  in  1  downstream accept
timeout  out  1  one-cycle pulse on measurement abort
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge) forces:
  - state to IDLE;
  - dl_arm, enc_en, ts_valid, timeout and busy to 0;
  - ts, enc_ip and the coarse counter to 0.
  - Reset mid-measurement or mid-handshake drops any pending timestamp without a timeout pulse.
- States: IDLE, ARMED, CAPTURE, ENCODE, OUTPUT.
- IDLE:
  - start=1 moves to ARMED and clears the coarse counter to 0.
  - start in any other state is ignored and not queued.
- ARMED (dl_arm=1):
  - Each cycle with stop_hit=0, coarse increments by 1.
  - stop_hit=1 moves to CAPTURE without incrementing; the coarse value is frozen.
  - If coarse==TIMEOUT and stop_hit=0: go to IDLE, pulse timeout for 1 cycle, produce no timestamp.
  - stop_hit=1 together with coarse==TIMEOUT: stop wins and the measurement proceeds.
  - stop_hit in the same cycle as start (state IDLE) is ignored.
- CAPTURE: enc_ip <= therm, then go to ENCODE.
- ENCODE:
  - enc_en=1 for exactly one cycle.
  - ts <= {coarse, enc_op}, ts_valid <= 1, then go to OUTPUT.
- Latency: stop_hit in ARMED -> ts_valid high 3 clk later.
- OUTPUT:
  - ts_valid and ts are held stable until ts_valid & ts_ready.
  - On accept: ts_valid <= 0, go to IDLE. A new start is accepted from the following cycle.
- therm=0 (no valid encoder match):
  - enc_op is undefined, so the controller substitutes fine=4'b0000 whenever enc_ip==0.
  - ts is never X.
- Coarse counter saturates by construction: TIMEOUT < 2^CW, so no wrap.

Optional Feature:
Macro TDC_BUBBLE_CHK_EN.
- Defined:
  - adds output port bubble_err (1 bit, reset 0);
  - in ENCODE, bubble_err <= 1 when enc_ip is not of the form 0…01…1 (a 0 below the highest 1); cleared on the OUTPUT accept;
  - ts is still produced from enc_op.
- Undefined: no port and no checking logic; behaviour otherwise identical.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles with start=1.
  - Required: all outputs 0, busy=0; after release with start low, state stays IDLE.
- Basic measurement:
  - Stimulus: start; stop_hit asserted on the 5th ARMED cycle; therm=16'h00FF; ts_ready=1.
  - Required: enc_en high 1 cycle, ts={8'd4, 4'd7}, ts_valid high 3 cycles after stop_hit, busy falls the cycle after accept.
- Backpressure:
  - Stimulus: as above but therm=16'h7FFF and ts_ready=0 for 10 cycles; pulse start twice during the stall.
  - Required: ts={8'd4, 4'hE} held stable, single timestamp only, no new measurement started.
- Timeout:
  - Stimulus: TIMEOUT=20 (override), start, never stop_hit.
  - Required: timeout pulses 1 cycle at coarse==20, no ts_valid, busy=0 next cycle.
- Boundary:
  - Stimulus: stop_hit coincident with coarse==TIMEOUT.
  - Required: ts coarse field = TIMEOUT, no timeout pulse.
  - Stimulus: therm=16'h0000.
  - Required: ts fine field=0.
- Reset mid-OUTPUT:
  - Stimulus: rst_n low while ts_valid=1; with TDC_BUBBLE_CHK_EN, therm=16'h00F7.
  - Required: before reset, bubble_err=1 and fine=7; after reset, ts_valid=0 and bubble_err=0.

Source files
------------

// File: rtl/tdc_meas_ctrl_if.sv
// Timestamp handshake and external priority-encoder bus for tdc_meas_ctrl.
// master = controller side, slave = readout/encoder side.
interface tdc_meas_ctrl_if #(parameter int CW = 8);
    logic [CW+3:0] ts;
    logic          ts_valid;
    logic          ts_ready;
    logic          enc_en;
    logic [15:0]   enc_ip;
    logic [3:0]    enc_op;

    modport master (output ts, ts_valid, enc_en, enc_ip, input ts_ready, enc_op);
    modport slave  (input ts, ts_valid, enc_en, enc_ip, output ts_ready, enc_op);
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the 16-tap delay-line TDC: arm, coarse count, capture, encode, handshake out.
// Optional thermometer bubble checking (bubble_err port) is enabled by defining TDC_BUBBLE_CHK_EN.
module tdc_meas_ctrl #(
    parameter int CW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop_hit,
    input  logic [15:0]    therm,
    output logic           dl_arm,
    output logic           timeout,
    output logic           busy,
`ifdef TDC_BUBBLE_CHK_EN
    output logic           bubble_err,
`endif
    tdc_meas_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, ENCODE, OUTPUT} state_t;

    localparam logic [CW-1:0] TO  = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state;
    logic [CW-1:0] coarse;
    logic [3:0]    fine;

    // An all-zero capture has no encoder match; force a defined fine code.
    assign fine = (bus.enc_ip == 16'd0) ? 4'd0 : bus.enc_op;

`ifdef TDC_BUBBLE_CHK_EN
    // Valid thermometer 0..01..1 has no bit set above a carry from +1.
    logic bubble;
    assign bubble = |(bus.enc_ip & (bus.enc_ip + 16'd1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            coarse       <= '0;
            dl_arm       <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            bus.enc_en   <= 1'b0;
            bus.enc_ip   <= 16'd0;
            bus.ts       <= '0;
            bus.ts_valid <= 1'b0;
`ifdef TDC_BUBBLE_CHK_EN
            bubble_err   <= 1'b0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ARMED;
                        coarse <= '0;
                        dl_arm <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ARMED: begin
                    // Stop beats timeout when both land in the same cycle.
                    if (stop_hit) begin
                        state  <= CAPTURE;
                        dl_arm <= 1'b0;
                    end else if (coarse == TO) begin
                        state   <= IDLE;
                        dl_arm  <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        coarse <= coarse + ONE;
                    end
                end
                CAPTURE: begin
                    bus.enc_ip <= therm;
                    bus.enc_en <= 1'b1;
                    state      <= ENCODE;
                end
                ENCODE: begin
                    bus.enc_en   <= 1'b0;
                    bus.ts       <= {coarse, fine};
                    bus.ts_valid <= 1'b1;
`ifdef TDC_BUBBLE_CHK_EN
                    bubble_err   <= bubble;
`endif
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.ts_ready) begin
                        bus.ts_valid <= 1'b0;
                        busy         <= 1'b0;
`ifdef TDC_BUBBLE_CHK_EN
                        bubble_err   <= 1'b0;
`endif
                        state        <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dl_arm <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl (CW=8, TIMEOUT=20) with a behavioural priority encoder.
module tb_tdc_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop_hit;
    logic [15:0] therm;
    logic        dl_arm;
    logic        timeout;
    logic        busy;
    logic        bubble_err;
    int          n_chk  = 0;
    int          n_pass = 0;

    tdc_meas_ctrl_if #(.CW(8)) bus ();

    always #5 clk = ~clk;

`ifdef TDC_BUBBLE_CHK_EN
    tdc_meas_ctrl #(.CW(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_hit(stop_hit), .therm(therm),
        .dl_arm(dl_arm), .timeout(timeout), .busy(busy), .bubble_err(bubble_err), .bus(bus));
`else
    assign bubble_err = 1'b0;
    tdc_meas_ctrl #(.CW(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_hit(stop_hit), .therm(therm),
        .dl_arm(dl_arm), .timeout(timeout), .busy(busy), .bus(bus));
`endif

    // External encoder: index of highest set bit; garbage (F) when disabled or no match.
    always_comb begin
        bus.enc_op = 4'hF;
        if (bus.enc_en && bus.enc_ip != 16'd0)
            for (int i = 0; i < 16; i++)
                if (bus.enc_ip[i]) bus.enc_op = 4'(i);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start, run to ARMED cycle `stop_cyc`, raise stop, and walk to OUTPUT.
    task automatic measure(input int stop_cyc, input logic [15:0] t);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(stop_cyc - 1);
        stop_hit = 1'b1;
        therm    = t;
        tick();
        stop_hit = 1'b0;
        tick();
        chk("enc_en_pulse", bus.enc_en, 1'b1);
        chk("enc_ip", bus.enc_ip, t);
        chk("no_valid_early", bus.ts_valid, 1'b0);
        tick();
        chk("ts_valid_lat3", bus.ts_valid, 1'b1);
        chk("enc_en_off", bus.enc_en, 1'b0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b1; stop_hit = 1'b0; therm = 16'd0; bus.ts_ready = 1'b0;
        tick(3);
        chk("rst_dl_arm", dl_arm, 1'b0);
        chk("rst_enc_en", bus.enc_en, 1'b0);
        chk("rst_ts_valid", bus.ts_valid, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ts", bus.ts, 12'h000);
        chk("rst_enc_ip", bus.enc_ip, 16'h0000);
        chk("rst_bubble", bubble_err, 1'b0);
        rst_n = 1'b1; start = 1'b0;
        tick(2);
        chk("idle_busy", busy, 1'b0);
        chk("idle_dl_arm", dl_arm, 1'b0);

        // Basic: stop on 5th ARMED cycle -> coarse 4, 0x00FF -> fine 7
        bus.ts_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("armed_dl_arm", dl_arm, 1'b1);
        chk("armed_busy", busy, 1'b1);
        tick(4);
        stop_hit = 1'b1; therm = 16'h00FF;
        tick();
        stop_hit = 1'b0;
        chk("capture_dl_arm", dl_arm, 1'b0);
        tick();
        chk("enc_en_pulse", bus.enc_en, 1'b1);
        chk("no_valid_early", bus.ts_valid, 1'b0);
        tick();
        chk("ts_valid_lat3", bus.ts_valid, 1'b1);
        chk("basic_ts", bus.ts, 12'h047);
        chk("busy_at_accept", busy, 1'b1);
        tick();
        chk("accept_valid", bus.ts_valid, 1'b0);
        chk("accept_busy", busy, 1'b0);

        // Backpressure with two ignored start pulses
        bus.ts_ready = 1'b0;
        measure(5, 16'h7FFF);
        chk("bp_ts", bus.ts, 12'h04E);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3 || c == 6);
            tick();
            if (bus.ts_valid !== 1'b1 || bus.ts !== 12'h04E || dl_arm !== 1'b0) seen++;
        end
        start = 1'b0;
        chk("bp_held_stable", seen, 0);
        bus.ts_ready = 1'b1;
        tick();
        chk("bp_accept_valid", bus.ts_valid, 1'b0);
        tick(2);
        chk("bp_no_restart", busy, 1'b0);
        chk("bp_no_second_ts", bus.ts_valid, 1'b0);

        // Timeout at coarse == 20
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (timeout !== 1'b0 || bus.ts_valid !== 1'b0) seen++;
        end
        chk("to_not_early", seen, 0);
        chk("to_busy_before", busy, 1'b1);
        tick();
        chk("to_pulse", timeout, 1'b1);
        chk("to_busy_off", busy, 1'b0);
        chk("to_no_valid", bus.ts_valid, 1'b0);
        tick();
        chk("to_pulse_1cyc", timeout, 1'b0);

        // Stop coincident with coarse == TIMEOUT, therm = 0
        measure(21, 16'h0000);
        chk("bnd_ts", bus.ts, 12'h140);
        chk("bnd_no_timeout", timeout, 1'b0);
        tick();
        chk("bnd_accept", busy, 1'b0);

        // Reset in OUTPUT with a bubbled word
        bus.ts_ready = 1'b0;
        measure(1, 16'h00F7);
        chk("rmo_ts", bus.ts, 12'h007);
`ifdef TDC_BUBBLE_CHK_EN
        chk("rmo_bubble_set", bubble_err, 1'b1);
`endif
        rst_n = 1'b0;
        tick();
        chk("rmo_valid", bus.ts_valid, 1'b0);
        chk("rmo_busy", busy, 1'b0);
        chk("rmo_ts_clr", bus.ts, 12'h000);
        chk("rmo_timeout", timeout, 1'b0);
        chk("rmo_bubble_clr", bubble_err, 1'b0);
        rst_n = 1'b1;
        tick(2);
        chk("rmo_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
